fpioa_cfg_seq: RTL and testbench

//  Pin-map configuration sequencer and register-port arbiter in front of the FPIOA.

---
 rtl/fpioa_cfg_seq_pkg.sv | 36 +++
 rtl/fpioa_port_mux.sv | 47 ++++
 rtl/fpioa_cfg_seq.sv | 155 +++++++++++++++
 tb/tb_fpioa_cfg_seq.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpioa_cfg_seq_pkg.sv
// Shared definitions for the FPIOA configuration sequencer: state encoding,
// table entry layout, end-of-table marker and FPIOA register offsets.
package fpioa_cfg_seq_pkg;

  localparam int unsigned ENT_W    = 44;
  localparam int unsigned FADDR_W  = 8;
  localparam int unsigned FDATA_W  = 32;
  localparam int unsigned FSEL_W   = 4;

  localparam logic [7:0] END_ADDR_DEF = 8'hFF;

  // FPIOA register offsets
  localparam logic [7:0] REG_OMAP     = 8'h00;
  localparam logic [7:0] REG_DIN      = 8'h20;
  localparam logic [7:0] REG_DOUT     = 8'h24;
  localparam logic [7:0] REG_DIR      = 8'h28;
  localparam logic [7:0] REG_ELI_EDGE = 8'h2C;
  localparam logic [7:0] REG_ELI_MODE = 8'h30;
  localparam logic [7:0] REG_IMAP     = 8'h80;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LATCH = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } seq_state_t;

  // Table entry as stored: {addr[43:36], sel[35:32], data[31:0]}
  typedef struct packed {
    logic [FADDR_W-1:0] addr;
    logic [FSEL_W-1:0]  sel;
    logic [FDATA_W-1:0] data;
  } tbl_entry_t;

endpackage

// File: rtl/fpioa_port_mux.sv
// Combinational arbiter for the single FPIOA register port: CPU writes win,
// the sequencer writes otherwise, reads always pass straight through.
module fpioa_port_mux
  import fpioa_cfg_seq_pkg::*;
(
  input  logic               i_h_we,
  input  logic [FADDR_W-1:0] i_h_waddr,
  input  logic [FDATA_W-1:0] i_h_data,
  input  logic [FSEL_W-1:0]  i_h_sel,
  input  logic [FADDR_W-1:0] i_h_raddr,
  input  logic               i_h_rd,
  input  logic               i_seq_we,
  input  tbl_entry_t         i_seq_entry,
  input  logic [FDATA_W-1:0] i_f_data,
  output logic [FADDR_W-1:0] o_f_waddr,
  output logic [FDATA_W-1:0] o_f_data,
  output logic [FSEL_W-1:0]  o_f_sel,
  output logic               o_f_we,
  output logic [FADDR_W-1:0] o_f_raddr,
  output logic               o_f_rd,
  output logic [FDATA_W-1:0] o_h_data
);

  // Idle write port carries the read address: FPIOA decodes the read region from waddr
  always_comb begin
    o_f_we    = 1'b0;
    o_f_waddr = i_h_raddr;
    o_f_data  = '0;
    o_f_sel   = '0;
    if (i_h_we) begin
      o_f_we    = 1'b1;
      o_f_waddr = i_h_waddr;
      o_f_data  = i_h_data;
      o_f_sel   = i_h_sel;
    end else if (i_seq_we) begin
      o_f_we    = 1'b1;
      o_f_waddr = i_seq_entry.addr;
      o_f_data  = i_seq_entry.data;
      o_f_sel   = i_seq_entry.sel;
    end
  end

  assign o_f_raddr = i_h_raddr;
  assign o_f_rd    = i_h_rd;
  assign o_h_data  = i_f_data;

endmodule

// File: rtl/fpioa_cfg_seq.sv
// Pin-map configuration sequencer: walks a {addr,sel,data} table and writes each
// entry into the FPIOA, sharing the register port with the CPU (CPU first).
module fpioa_cfg_seq
  import fpioa_cfg_seq_pkg::*;
#(
  parameter int unsigned TBL_AW   = 6,
  parameter logic [7:0]  END_ADDR = END_ADDR_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [FADDR_W-1:0]  h_waddr_i,
  input  logic [FDATA_W-1:0]  h_data_i,
  input  logic [FSEL_W-1:0]   h_sel_i,
  input  logic                h_we_i,
  input  logic [FADDR_W-1:0]  h_raddr_i,
  input  logic                h_rd_i,
  output logic [FDATA_W-1:0]  h_data_o,
  input  logic                start_i,
  input  logic                abort_i,
  input  logic [TBL_AW-1:0]   base_i,
  input  logic [TBL_AW:0]     count_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                err_o,
  output logic [TBL_AW-1:0]   tbl_addr_o,
  output logic                tbl_rd_o,
  input  logic [ENT_W-1:0]    tbl_data_i,
  output logic [FADDR_W-1:0]  f_waddr_o,
  output logic [FDATA_W-1:0]  f_data_o,
  output logic [FSEL_W-1:0]   f_sel_o,
  output logic                f_we_o,
  output logic [FADDR_W-1:0]  f_raddr_o,
  output logic                f_rd_o,
  input  logic [FDATA_W-1:0]  f_data_i
);

  localparam int unsigned RW = TBL_AW + 1;

  seq_state_t        r_state, w_nxt_state;
  logic [TBL_AW-1:0] r_idx, w_nxt_idx;
  logic [RW-1:0]     r_rem, w_nxt_rem;
  logic              r_err, w_nxt_err;
  logic              r_busy, r_done, r_tbl_rd;
  logic [TBL_AW-1:0] r_tbl_addr;
  tbl_entry_t        r_entry;
  tbl_entry_t        w_tbl_ent;
  logic              w_latch;
  logic              w_seq_we;

  assign w_tbl_ent = tbl_entry_t'(tbl_data_i);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_rem      <= '0;
      r_err      <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_tbl_rd   <= 1'b0;
      r_tbl_addr <= '0;
      r_entry    <= '0;
    end else begin
      r_state    <= w_nxt_state;
      r_idx      <= w_nxt_idx;
      r_rem      <= w_nxt_rem;
      r_err      <= w_nxt_err;
      r_busy     <= (w_nxt_state != S_IDLE);
      r_done     <= (w_nxt_state == S_DONE);
      r_tbl_rd   <= (w_nxt_state == S_FETCH);
      r_tbl_addr <= w_nxt_idx;
      if (w_latch) r_entry <= w_tbl_ent;
    end
  end

  // Next state; abort in an active state suppresses that cycle's write and ends the run
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_idx   = r_idx;
    w_nxt_rem   = r_rem;
    w_nxt_err   = r_err;
    w_latch     = 1'b0;
    w_seq_we    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start_i) begin
          w_nxt_err = 1'b0;
          if (count_i != '0) begin
            w_nxt_idx   = base_i;
            w_nxt_rem   = count_i;
            w_nxt_state = S_FETCH;
          end else begin
            w_nxt_state = S_DONE;
          end
        end
      end
      S_FETCH: begin
        if (abort_i) begin
          w_nxt_err   = 1'b1;
          w_nxt_state = S_DONE;
        end else begin
          w_nxt_state = S_LATCH;
        end
      end
      S_LATCH: begin
        if (abort_i) begin
          w_nxt_err   = 1'b1;
          w_nxt_state = S_DONE;
        end else begin
          w_latch     = 1'b1;
          w_nxt_state = (w_tbl_ent.addr == END_ADDR) ? S_DONE : S_WRITE;
        end
      end
      S_WRITE: begin
        if (abort_i) begin
          w_nxt_err   = 1'b1;
          w_nxt_state = S_DONE;
        end else if (!h_we_i) begin
          w_seq_we    = 1'b1;
          w_nxt_idx   = r_idx + TBL_AW'(1);
          w_nxt_rem   = r_rem - RW'(1);
          w_nxt_state = (r_rem == RW'(1)) ? S_DONE : S_FETCH;
        end
      end
      S_DONE:  w_nxt_state = S_IDLE;
      default: w_nxt_state = S_IDLE;
    endcase
  end

  fpioa_port_mux u_port_mux (
    .i_h_we      (h_we_i),
    .i_h_waddr   (h_waddr_i),
    .i_h_data    (h_data_i),
    .i_h_sel     (h_sel_i),
    .i_h_raddr   (h_raddr_i),
    .i_h_rd      (h_rd_i),
    .i_seq_we    (w_seq_we),
    .i_seq_entry (r_entry),
    .i_f_data    (f_data_i),
    .o_f_waddr   (f_waddr_o),
    .o_f_data    (f_data_o),
    .o_f_sel     (f_sel_o),
    .o_f_we      (f_we_o),
    .o_f_raddr   (f_raddr_o),
    .o_f_rd      (f_rd_o),
    .o_h_data    (h_data_o)
  );

  assign busy_o     = r_busy;
  assign done_o     = r_done;
  assign err_o      = r_err;
  assign tbl_rd_o   = r_tbl_rd;
  assign tbl_addr_o = r_tbl_addr;

endmodule

// File: tb/tb_fpioa_cfg_seq.sv
// Directed bench for fpioa_cfg_seq: table model, cycle-indexed stimulus, inline checks.
`timescale 1ns/1ps
module tb_fpioa_cfg_seq;
  import fpioa_cfg_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  h_waddr_i, h_raddr_i;
  logic [31:0] h_data_i, h_data_o;
  logic [3:0]  h_sel_i;
  logic        h_we_i, h_rd_i;
  logic        start_i, abort_i;
  logic [5:0]  base_i;
  logic [6:0]  count_i;
  logic        busy_o, done_o, err_o;
  logic [5:0]  tbl_addr_o;
  logic        tbl_rd_o;
  logic [43:0] tbl_data_i;
  logic [7:0]  f_waddr_o, f_raddr_o;
  logic [31:0] f_data_o, f_data_i;
  logic [3:0]  f_sel_o;
  logic        f_we_o, f_rd_o;

  logic [43:0] tbl [64];
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // Synchronous table memory: data valid one cycle after the read strobe
  always @(posedge clk) if (tbl_rd_o) tbl_data_i <= tbl[tbl_addr_o];

  fpioa_cfg_seq #(.TBL_AW(6), .END_ADDR(8'hFF)) dut (
    .clk(clk), .rst(rst),
    .h_waddr_i(h_waddr_i), .h_data_i(h_data_i), .h_sel_i(h_sel_i), .h_we_i(h_we_i),
    .h_raddr_i(h_raddr_i), .h_rd_i(h_rd_i), .h_data_o(h_data_o),
    .start_i(start_i), .abort_i(abort_i), .base_i(base_i), .count_i(count_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .tbl_addr_o(tbl_addr_o), .tbl_rd_o(tbl_rd_o), .tbl_data_i(tbl_data_i),
    .f_waddr_o(f_waddr_o), .f_data_o(f_data_o), .f_sel_o(f_sel_o), .f_we_o(f_we_o),
    .f_raddr_o(f_raddr_o), .f_rd_o(f_rd_o), .f_data_i(f_data_i)
  );

  task automatic quiet_inputs();
    h_waddr_i = '0; h_data_i = '0; h_sel_i = '0; h_we_i = 1'b0;
    h_raddr_i = '0; h_rd_i = 1'b0; start_i = 1'b0; abort_i = 1'b0;
    base_i = '0; count_i = '0; f_data_i = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic load_basic_table();
    tbl[0] = {REG_OMAP,     4'hF, 32'h0000_0201};
    tbl[1] = {REG_DIR,      4'hF, 32'h0000_0000};
    tbl[2] = {REG_ELI_EDGE, 4'hF, 32'hFFFF_FFFF};
  endtask

  task automatic test_reset();
    rst = 1'b1;
    quiet_inputs();
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if ({busy_o, done_o, err_o, tbl_rd_o, f_we_o} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_flags got %b exp 00000", {busy_o, done_o, err_o, tbl_rd_o, f_we_o});
    end
    n_tests++;
    if (tbl_addr_o !== 6'd0) begin
      n_fail++; $display("FAIL reset_tbl_addr got %0d exp 0", tbl_addr_o);
    end
    rst = 1'b0;
    next_cycle();
  endtask

  task automatic test_basic();
    logic [43:0] exp_ent;
    logic        exp_we;
    load_basic_table();
    for (int k = 0; k <= 12; k++) begin
      start_i = (k == 0); base_i = 6'd0; count_i = 7'd3;
      @(negedge clk);
      exp_we = (k == 3 || k == 6 || k == 9);
      n_tests++;
      if (f_we_o !== exp_we) begin
        n_fail++; $display("FAIL basic_we k=%0d got %b exp %b", k, f_we_o, exp_we);
      end
      if (exp_we) begin
        exp_ent = tbl[k/3 - 1];
        n_tests++;
        if ({f_waddr_o, f_sel_o, f_data_o} !== exp_ent) begin
          n_fail++; $display("FAIL basic_entry k=%0d got %h exp %h", k, {f_waddr_o, f_sel_o, f_data_o}, exp_ent);
        end
      end
      n_tests++;
      if (done_o !== (k == 10)) begin
        n_fail++; $display("FAIL basic_done k=%0d got %b exp %b", k, done_o, (k == 10));
      end
      next_cycle();
    end
    n_tests++;
    if (err_o !== 1'b0 || busy_o !== 1'b0) begin
      n_fail++; $display("FAIL basic_end err=%b busy=%b exp 0 0", err_o, busy_o);
    end
  endtask

  task automatic test_cpu_stall();
    logic [43:0] exp_ent;
    logic        exp_we;
    load_basic_table();
    for (int k = 0; k <= 14; k++) begin
      start_i = (k == 0); base_i = 6'd0; count_i = 7'd3;
      h_we_i  = (k == 6 || k == 7);
      h_waddr_i = REG_DOUT; h_sel_i = 4'h3; h_data_i = 32'hA5A5_0000 + 32'(k);
      @(negedge clk);
      exp_we = (k == 3 || k == 6 || k == 7 || k == 8 || k == 11);
      if (k == 6 || k == 7) exp_ent = {REG_DOUT, 4'h3, 32'hA5A5_0000 + 32'(k)};
      else if (k == 3)      exp_ent = tbl[0];
      else if (k == 8)      exp_ent = tbl[1];
      else                  exp_ent = tbl[2];
      n_tests++;
      if (f_we_o !== exp_we) begin
        n_fail++; $display("FAIL stall_we k=%0d got %b exp %b", k, f_we_o, exp_we);
      end
      if (exp_we) begin
        n_tests++;
        if ({f_waddr_o, f_sel_o, f_data_o} !== exp_ent) begin
          n_fail++; $display("FAIL stall_entry k=%0d got %h exp %h", k, {f_waddr_o, f_sel_o, f_data_o}, exp_ent);
        end
      end
      n_tests++;
      if (done_o !== (k == 12)) begin
        n_fail++; $display("FAIL stall_done k=%0d got %b exp %b", k, done_o, (k == 12));
      end
      next_cycle();
    end
    quiet_inputs();
  endtask

  task automatic test_wrap();
    logic [5:0]  exp_addr [4];
    logic [43:0] exp_ent;
    exp_addr[0] = 6'd62; exp_addr[1] = 6'd63; exp_addr[2] = 6'd0; exp_addr[3] = 6'd1;
    tbl[62] = {REG_IMAP,     4'h1, 32'h0000_0062};
    tbl[63] = {REG_DIN,      4'h2, 32'h0000_0063};
    tbl[0]  = {REG_ELI_MODE, 4'h4, 32'h0000_0100};
    tbl[1]  = {REG_DOUT,     4'h8, 32'h0000_0101};
    for (int k = 0; k <= 14; k++) begin
      start_i = (k == 0); base_i = 6'd62; count_i = 7'd4;
      @(negedge clk);
      n_tests++;
      if (tbl_rd_o !== (k % 3 == 1 && k <= 10)) begin
        n_fail++; $display("FAIL wrap_rd k=%0d got %b", k, tbl_rd_o);
      end
      if (k % 3 == 1 && k <= 10) begin
        n_tests++;
        if (tbl_addr_o !== exp_addr[k/3]) begin
          n_fail++; $display("FAIL wrap_addr k=%0d got %0d exp %0d", k, tbl_addr_o, exp_addr[k/3]);
        end
      end
      n_tests++;
      if (f_we_o !== (k % 3 == 0 && k >= 3 && k <= 12)) begin
        n_fail++; $display("FAIL wrap_we k=%0d got %b", k, f_we_o);
      end
      if (k % 3 == 0 && k >= 3 && k <= 12) begin
        exp_ent = tbl[exp_addr[k/3 - 1]];
        n_tests++;
        if ({f_waddr_o, f_sel_o, f_data_o} !== exp_ent) begin
          n_fail++; $display("FAIL wrap_entry k=%0d got %h exp %h", k, {f_waddr_o, f_sel_o, f_data_o}, exp_ent);
        end
      end
      n_tests++;
      if (done_o !== (k == 13)) begin
        n_fail++; $display("FAIL wrap_done k=%0d got %b exp %b", k, done_o, (k == 13));
      end
      next_cycle();
    end
  endtask

  task automatic test_end_marker();
    tbl[0] = {REG_ELI_MODE, 4'hF, 32'h0000_0011};
    tbl[1] = {8'hFF,        4'hF, 32'hDEAD_BEEF};
    tbl[2] = {REG_DIR,      4'hF, 32'h0000_0022};
    for (int k = 0; k <= 9; k++) begin
      start_i = (k == 0); base_i = 6'd0; count_i = 7'd5;
      @(negedge clk);
      n_tests++;
      if (f_we_o !== (k == 3)) begin
        n_fail++; $display("FAIL end_we k=%0d got %b exp %b", k, f_we_o, (k == 3));
      end
      n_tests++;
      if (done_o !== (k == 6)) begin
        n_fail++; $display("FAIL end_done k=%0d got %b exp %b", k, done_o, (k == 6));
      end
      next_cycle();
    end
    n_tests++;
    if (err_o !== 1'b0) begin
      n_fail++; $display("FAIL end_err got %b exp 0", err_o);
    end
  endtask

  task automatic test_abort();
    load_basic_table();
    for (int k = 0; k <= 9; k++) begin
      start_i = (k == 0 || k == 4);
      base_i  = (k == 4) ? 6'd5 : 6'd0;
      count_i = (k == 4) ? 7'd1 : 7'd3;
      abort_i = (k == 6);
      @(negedge clk);
      n_tests++;
      if (f_we_o !== (k == 3)) begin
        n_fail++; $display("FAIL abort_we k=%0d got %b exp %b", k, f_we_o, (k == 3));
      end
      n_tests++;
      if (done_o !== (k == 7)) begin
        n_fail++; $display("FAIL abort_done k=%0d got %b exp %b", k, done_o, (k == 7));
      end
      n_tests++;
      if (err_o !== (k >= 7)) begin
        n_fail++; $display("FAIL abort_err k=%0d got %b exp %b", k, err_o, (k >= 7));
      end
      n_tests++;
      if (tbl_rd_o !== (k == 1 || k == 4)) begin
        n_fail++; $display("FAIL abort_rd k=%0d got %b", k, tbl_rd_o);
      end
      next_cycle();
    end
    // count of zero with a coincident abort: start wins and clears the sticky error
    for (int k = 0; k <= 3; k++) begin
      start_i = (k == 0); abort_i = (k == 0); base_i = 6'd0; count_i = 7'd0;
      @(negedge clk);
      n_tests++;
      if (done_o !== (k == 1)) begin
        n_fail++; $display("FAIL zero_done k=%0d got %b exp %b", k, done_o, (k == 1));
      end
      n_tests++;
      if (busy_o !== (k == 1)) begin
        n_fail++; $display("FAIL zero_busy k=%0d got %b exp %b", k, busy_o, (k == 1));
      end
      n_tests++;
      if (tbl_rd_o !== 1'b0 || f_we_o !== 1'b0) begin
        n_fail++; $display("FAIL zero_access k=%0d rd=%b we=%b exp 0 0", k, tbl_rd_o, f_we_o);
      end
      if (k >= 1) begin
        n_tests++;
        if (err_o !== 1'b0) begin
          n_fail++; $display("FAIL zero_err_clear k=%0d got %b exp 0", k, err_o);
        end
      end
      next_cycle();
    end
    quiet_inputs();
  endtask

  task automatic test_read_and_reset();
    logic [7:0]  raddr;
    logic [31:0] fdat;
    load_basic_table();
    for (int k = 0; k <= 6; k++) begin
      raddr = 8'(k * 4 + 8'h40);
      fdat  = 32'hC0DE_0000 | 32'(k);
      start_i = (k == 0); base_i = 6'd0; count_i = 7'd3;
      h_rd_i = 1'b1; h_raddr_i = raddr; f_data_i = fdat;
      @(negedge clk);
      n_tests++;
      if (f_rd_o !== 1'b1 || f_raddr_o !== raddr) begin
        n_fail++; $display("FAIL rd_pass k=%0d rd=%b raddr=%h exp 1 %h", k, f_rd_o, f_raddr_o, raddr);
      end
      n_tests++;
      if (h_data_o !== fdat) begin
        n_fail++; $display("FAIL rd_data k=%0d got %h exp %h", k, h_data_o, fdat);
      end
      if (k == 1) begin
        n_tests++;
        if (f_we_o !== 1'b0 || f_waddr_o !== raddr || f_data_o !== 32'h0 || f_sel_o !== 4'h0) begin
          n_fail++; $display("FAIL idle_port k=%0d we=%b waddr=%h exp 0 %h", k, f_we_o, f_waddr_o, raddr);
        end
      end
      if (k == 3) begin
        n_tests++;
        if (f_we_o !== 1'b1 || f_waddr_o !== REG_OMAP) begin
          n_fail++; $display("FAIL rd_seq_write k=%0d we=%b waddr=%h exp 1 %h", k, f_we_o, f_waddr_o, REG_OMAP);
        end
      end
      if (k < 6) next_cycle();
    end
    // in WRITE of entry 1: assert reset between edges
    n_tests++;
    if (f_we_o !== 1'b1) begin
      n_fail++; $display("FAIL pre_reset_we got %b exp 1", f_we_o);
    end
    #1 rst = 1'b1;
    #1;
    n_tests++;
    if (f_we_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b0) begin
      n_fail++; $display("FAIL async_reset we=%b busy=%b done=%b exp 0 0 0", f_we_o, busy_o, done_o);
    end
    next_cycle();
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      n_tests++;
      if (done_o !== 1'b0 || busy_o !== 1'b0) begin
        n_fail++; $display("FAIL post_reset k=%0d done=%b busy=%b exp 0 0", k, done_o, busy_o);
      end
      next_cycle();
    end
    quiet_inputs();
  endtask

  initial begin
    tbl_data_i = '0;
    for (int i = 0; i < 64; i++) tbl[i] = {8'h10, 4'h0, 32'(i)};
    test_reset();
    test_basic();
    next_cycle();
    test_cpu_stall();
    next_cycle();
    test_wrap();
    next_cycle();
    test_end_marker();
    next_cycle();
    test_abort();
    next_cycle();
    test_read_and_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
